// File: rtl/araddr_fifo_pkg.sv
// rtl/araddr_fifo_pkg.sv - shared FSM encoding, FIFO word layout and AXI constants
package araddr_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ADDR = 2'd2
  } rd_state_t;

  // FIFO word is {arlen, araddr}; arlen sits directly above the address field
  localparam int ARADDR_LSB = 0;
  localparam int ARLEN_W    = 8;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  function automatic int arlen_lsb(input int addr_w);
    return ARADDR_LSB + addr_w;
  endfunction

endpackage

// File: rtl/araddr_fifo_reader_outstanding_ctr.sv
// rtl/araddr_fifo_reader_outstanding_ctr.sv - in-flight burst up/down counter with sticky underflow
module outstanding_ctr #(
  parameter int c_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] count,
  output logic       err_underflow
);

  localparam logic [3:0] MAX_CNT = 4'(c_MAX);

  // simultaneous inc and dec cancel; a stray completion at zero is flagged, not wrapped
  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= 4'd0;
      err_underflow <= 1'b0;
    end else if (inc && !dec) begin
      if (count < MAX_CNT) begin
        count <= count + 4'd1;
      end
    end else if (dec && !inc) begin
      if (count == 4'd0) begin
        err_underflow <= 1'b1;
      end else begin
        count <= count - 4'd1;
      end
    end
  end

endmodule

// File: rtl/araddr_fifo_reader.sv
// rtl/araddr_fifo_reader.sv - pops AR requests from an external FIFO and issues them on AXI AR
module araddr_fifo_reader
  import araddr_fifo_pkg::*;
#(
  parameter int         c_ADDR_WIDTH      = 28,
  parameter int         c_OUTPUT_REG      = 0,
  parameter int         c_MAX_OUTSTANDING = 4,
  parameter logic [2:0] c_ARSIZE          = 3'b011
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst,
  input  logic [c_ADDR_WIDTH+7:0] rd_data,
  input  logic                    rd_empty,
  output logic                    rd_en,
  output logic                    rd_oce,
  output logic [c_ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic                    m_rvalid,
  input  logic                    m_rready,
  input  logic                    m_rlast,
  output logic [3:0]              outstanding,
  output logic                    busy,
  output logic                    err_underflow
);

  localparam logic [3:0] MAX_CNT   = 4'(c_MAX_OUTSTANDING);
  localparam logic [1:0] WAIT_LAST = 2'(c_OUTPUT_REG);
  localparam int         LEN_LSB   = arlen_lsb(c_ADDR_WIDTH);

  rd_state_t             state, state_nxt;
  logic [1:0]            wait_cnt;
  logic                  wait_last;
  logic                  can_issue;
  logic                  ar_hs;
  logic                  r_done;
  logic [c_ADDR_WIDTH-1:0] hold_addr;
  logic [7:0]            hold_len;

  assign wait_last = (wait_cnt == WAIT_LAST);
  assign can_issue = !rd_empty && (outstanding < MAX_CNT);
  assign ar_hs     = m_arvalid && m_arready;
  assign r_done    = m_rvalid && m_rready && m_rlast;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (can_issue) state_nxt = ST_WAIT;
      ST_WAIT: if (wait_last) state_nxt = ST_ADDR;
      ST_ADDR: if (m_arready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_en     = (state == ST_IDLE) && can_issue && !rd_rst;
    m_arvalid = (state == ST_ADDR);
    busy      = (state != ST_IDLE) || (outstanding != 4'd0);
  end

  // wait_cnt restarts at zero on every entry to WAIT, matching FIFO read latency
  always_ff @(posedge rd_clk) begin
    if (rd_rst || state != ST_WAIT) begin
      wait_cnt <= 2'd0;
    end else begin
      wait_cnt <= wait_cnt + 2'd1;
    end
  end

  // the AR payload is driven only from this register so it cannot move while stalled
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      hold_addr <= '0;
      hold_len  <= 8'd0;
    end else if (state == ST_WAIT && wait_last) begin
      hold_addr <= rd_data[ARADDR_LSB +: c_ADDR_WIDTH];
      hold_len  <= rd_data[LEN_LSB +: ARLEN_W];
    end
  end

  assign m_araddr  = hold_addr;
  assign m_arlen   = hold_len;
  assign m_arsize  = c_ARSIZE;
  assign m_arburst = AXI_BURST_INCR;
  assign rd_oce    = 1'b1;

  outstanding_ctr #(
    .c_MAX(c_MAX_OUTSTANDING)
  ) u_outstanding_ctr (
    .clk          (rd_clk),
    .rst          (rd_rst),
    .inc          (ar_hs),
    .dec          (r_done),
    .count        (outstanding),
    .err_underflow(err_underflow)
  );

endmodule

// File: doc/araddr_fifo_reader.md
ARADDR_FIFO_READER -- requirements
Module: araddr_fifo_reader

Interface
REQ-001 SHALL have parameter c_ADDR_WIDTH, default 28, AXI read address width.
REQ-002 SHALL have parameter c_OUTPUT_REG, default 0, read latency setting of the attached FIFO (0: data 1 cycle after rd_en; 1: 2 cycles).
REQ-003 SHALL have parameter c_MAX_OUTSTANDING, default 4, legal 1..15, maximum accepted-but-uncompleted read bursts.
REQ-004 SHALL have parameter c_ARSIZE, default 3'b011, constant AXI beat size.
REQ-005 rd_clk  input  1  sole clock; all logic on rising edge.
REQ-006 rd_rst  input  1  synchronous, active-high reset.
REQ-007 rd_data  input  c_ADDR_WIDTH+8  FIFO word: [c_ADDR_WIDTH+7:c_ADDR_WIDTH]=arlen, [c_ADDR_WIDTH-1:0]=araddr.
REQ-008 rd_empty  input  1  FIFO empty flag.
REQ-009 rd_en  output  1  FIFO pop strobe, one-cycle pulse.
REQ-010 rd_oce  output  1  FIFO output-register enable, constant 1.
REQ-011 m_araddr/m_arlen/m_arsize/m_arburst  output  c_ADDR_WIDTH/8/3/2  AXI AR payload; m_arburst constant 2'b01, m_arsize = c_ARSIZE.
REQ-012 m_arvalid output 1, m_arready input 1  AR handshake.
REQ-013 m_rvalid, m_rready, m_rlast  input  1 each  R-channel monitor (not driven by this block).
REQ-014 outstanding  output  4  current in-flight burst count.
REQ-015 busy output 1 (FSM not IDLE or outstanding != 0); err_underflow output 1, sticky.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, ADDR.
REQ-017 IDLE->WAIT when !rd_empty and outstanding < c_MAX_OUTSTANDING; rd_en=1 in that IDLE cycle only; otherwise stay IDLE, rd_en=0.
REQ-018 WAIT SHALL last exactly 1+c_OUTPUT_REG cycles counted from the rd_en cycle; in its last cycle rd_data is captured into the AR holding register and FSM moves to ADDR.
REQ-019 In ADDR m_arvalid=1; m_araddr/m_arlen SHALL come only from the holding register and stay stable until m_arvalid&&m_arready.
REQ-020 On m_arvalid&&m_arready FSM SHALL return to IDLE next cycle; m_arvalid deasserts same edge (no back-to-back; minimum 3+c_OUTPUT_REG cycles per burst).
REQ-021 rd_en SHALL never assert while rd_empty=1 or outside IDLE.
REQ-022 outstanding: +1 on AR handshake, -1 on m_rvalid&&m_rready&&m_rlast, unchanged when both in the same cycle.
REQ-023 Decrement at outstanding=0 (without simultaneous increment) SHALL leave count 0 and set err_underflow.
REQ-024 Count SHALL never exceed c_MAX_OUTSTANDING; at the limit FSM holds IDLE with a non-empty FIFO.
REQ-025 m_arvalid SHALL not depend combinationally on m_arready.

Reset
REQ-026 While rd_rst=1: FSM=IDLE, rd_en=0, m_arvalid=0, m_araddr=0, m_arlen=0, outstanding=0, err_underflow=0, busy=0, effective at the next edge.
REQ-027 Reset during WAIT or ADDR SHALL abandon the popped entry (not replayed); no AR handshake is counted in the reset cycle.
REQ-028 rd_oce, m_arsize, m_arburst are constants, unaffected by reset.

Structure
REQ-029 FSM state encodings, FIFO field offsets and the AXI INCR burst constant SHALL live in shared package araddr_fifo_pkg.
REQ-030 The outstanding up/down counter with saturation and underflow flag SHALL be one sub-module, outstanding_ctr.
REQ-031 No submodule SHALL instantiate FIFO memory; the FIFO is external.

Verification
REQ-032 Single entry {arlen=8'h0F, araddr=28'h0001000}, c_OUTPUT_REG=0, m_arready=1 -> rd_en at T0, m_arvalid at T2 with those values, outstanding=1 at T3.
REQ-033 c_OUTPUT_REG=1, same entry -> m_arvalid first at T3, payload equals entry.
REQ-034 6 entries, c_MAX_OUTSTANDING=4, no rlast -> exactly 4 AR handshakes, outstanding=4, rd_en stays 0; one rlast -> 5th AR issues.
REQ-035 m_arready held 0 for 10 cycles in ADDR -> m_arvalid, m_araddr, m_arlen constant all 10 cycles; single handshake on release.
REQ-036 AR handshake and rlast in same cycle at outstanding=2 -> stays 2; rlast at outstanding=0 -> stays 0, err_underflow=1 until reset.
REQ-037 rd_rst pulsed during ADDR -> m_arvalid=0 next cycle, outstanding=0, next FIFO entry issued normally after release.
